digit_entry_seq: RTL and testbench

DIGIT_ENTRY_SEQ -- requirements
Module: digit_entry_seq

---
 rtl/digit_entry_seq.sv | 106 ++++++++++
 tb/tb_digit_entry_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry_seq.sv
// Digit entry sequencer: each button press captures one switch digit into the next slot of a NUM_DIGITS register.
// Define DIGIT_BACK_EN to add the backspace button (port back).
module digit_entry_seq #(
   parameter int NUM_DIGITS = 4,
   parameter int DIGIT_W    = 4,
   parameter int DIGIT_MAX  = 9,
   localparam int POS_W     = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic                          clear,
   input  logic [DIGIT_W-1:0]            num,
`ifdef DIGIT_BACK_EN
   input  logic                          back,
`endif
   output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
   output logic [NUM_DIGITS-1:0]         wr_en,
   output logic [POS_W-1:0]              pos,
   output logic                          done,
   output logic                          err,
   output logic                          state
);

   typedef enum logic {WAIT_PRESS = 1'b0, WAIT_RELEASE = 1'b1} state_t;

   localparam logic [POS_W-1:0]   LAST_POS  = POS_W'(NUM_DIGITS - 1);
   localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(DIGIT_MAX);

   state_t st;
   logic   digit_ok;

   assign state    = st;
   assign digit_ok = (num <= MAX_DIGIT);

`ifdef DIGIT_BACK_EN
   logic             back_q;
   logic             back_rise;
   logic [POS_W-1:0] back_pos;

   // A completed entry backs up into its last digit; otherwise step back, stopping at 0.
   assign back_rise = back & ~back_q;
   assign back_pos  = done ? LAST_POS : ((pos == '0) ? '0 : pos - 1'b1);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st     <= WAIT_RELEASE;
         digits <= '0;
         wr_en  <= '0;
         pos    <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
`ifdef DIGIT_BACK_EN
         back_q <= 1'b0;
`endif
      end else begin
         wr_en <= '0;
         err   <= 1'b0;
`ifdef DIGIT_BACK_EN
         back_q <= back;
`endif
         if (clear) begin
            // Land in WAIT_RELEASE so a button still held from before is not captured.
            st     <= WAIT_RELEASE;
            digits <= '0;
            pos    <= '0;
            done   <= 1'b0;
         end else begin
            case (st)
               WAIT_PRESS: begin
                  if (enable) begin
                     st <= WAIT_RELEASE;
                     if (digit_ok) begin
                        digits[pos*DIGIT_W +: DIGIT_W] <= num;
                        wr_en <= NUM_DIGITS'(1) << pos;
                        if (pos == LAST_POS) begin
                           pos  <= '0;
                           done <= 1'b1;
                        end else begin
                           pos  <= pos + 1'b1;
                           done <= 1'b0;
                        end
                     end else begin
                        err <= 1'b1;
                     end
                  end
`ifdef DIGIT_BACK_EN
                  else if (back_rise) begin
                     pos   <= back_pos;
                     digits[back_pos*DIGIT_W +: DIGIT_W] <= '0;
                     wr_en <= NUM_DIGITS'(1) << back_pos;
                     done  <= 1'b0;
                  end
`endif
               end
               WAIT_RELEASE: begin
                  if (!enable) st <= WAIT_PRESS;
               end
               default: st <= WAIT_RELEASE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_digit_entry_seq.sv
// Bench for digit_entry_seq: fixed vector table, corner-case sequences and random stimulus
// checked against a slot/count model of digit entry.
module tb_digit_entry_seq;

   localparam int ND   = 4;
   localparam int DW   = 4;
   localparam int DMAX = 9;
   localparam int PW   = 2;
   localparam int W    = ND*DW + ND + PW + 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic          back = 1'b0;
   logic [DW-1:0] num = '0;

   logic [ND*DW-1:0] digits;
   logic [ND-1:0]    wr_en;
   logic [PW-1:0]    pos;
   logic             done;
   logic             err;
   logic             state;

   int vectors = 0;
   int miscompares = 0;
   logic [W-1:0] exp_q[$];

   int m_dig[ND];
   int m_pos;
   bit m_done;
   bit m_armed;
   bit m_back_prev;

   typedef struct {
      logic          en;
      logic          clr;
      logic [DW-1:0] n;
      logic          bk;
      logic [ND*DW-1:0] d;
      logic [ND-1:0] w;
      logic [PW-1:0] p;
      logic          dn;
      logic          er;
   } vec_t;
   vec_t tbl[13];

   digit_entry_seq #(.NUM_DIGITS(ND), .DIGIT_W(DW), .DIGIT_MAX(DMAX)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .clear(clear),
      .num(num),
`ifdef DIGIT_BACK_EN
      .back(back),
`endif
      .digits(digits),
      .wr_en(wr_en),
      .pos(pos),
      .done(done),
      .err(err),
      .state(state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < ND; i++) m_dig[i] = 0;
      m_pos = 0;
      m_done = 1'b0;
      m_armed = 1'b0;
      m_back_prev = 1'b0;
      exp_q.delete();
   endtask

   function automatic logic [W-1:0] model_out(input logic [ND-1:0] w, input logic e);
      logic [ND*DW-1:0] d;
      d = '0;
      for (int i = 0; i < ND; i++) d[i*DW +: DW] = DW'(m_dig[i]);
      return {d, w, PW'(m_pos), m_done, e};
   endfunction

   task automatic model_step(input logic en, input logic clr, input logic [DW-1:0] n, input logic bk);
      logic [ND-1:0] w;
      logic e;
      w = '0;
      e = 1'b0;
      if (clr) begin
         for (int i = 0; i < ND; i++) m_dig[i] = 0;
         m_pos = 0;
         m_done = 1'b0;
         m_armed = 1'b0;
      end else if (!m_armed) begin
         if (!en) m_armed = 1'b1;
      end else if (en) begin
         m_armed = 1'b0;
         if (int'(n) <= DMAX) begin
            m_dig[m_pos] = int'(n);
            w[m_pos] = 1'b1;
            m_done = (m_pos == ND - 1);
            m_pos = (m_pos + 1) % ND;
         end else begin
            e = 1'b1;
         end
      end
`ifdef DIGIT_BACK_EN
      else if (bk && !m_back_prev) begin
         if (m_done) begin
            m_pos = ND - 1;
            m_done = 1'b0;
         end else if (m_pos > 0) begin
            m_pos = m_pos - 1;
         end
         m_dig[m_pos] = 0;
         w[m_pos] = 1'b1;
      end
`endif
      m_back_prev = bk;
      exp_q.push_back(model_out(w, e));
   endtask

   // ---------------- drivers ----------------
   task automatic apply(input logic en, input logic clr, input logic [DW-1:0] n, input logic bk);
      @(negedge clk);
      enable = en;
      clear = clr;
      num = n;
      back = bk;
      @(posedge clk);
      model_step(en, clr, n, bk);
      #1;
      check("model", {digits, wr_en, pos, done, err}, exp_q.pop_front());
   endtask

   task automatic press(input logic [DW-1:0] n);
      apply(1'b1, 1'b0, n, 1'b0);
      apply(1'b0, 1'b0, n, 1'b0);
   endtask

   // Asynchronous reset asserted between edges, with enable optionally held through it.
   task automatic do_reset(input logic hold_en);
      @(posedge clk);
      #3;
      enable = hold_en;
      clear = 1'b0;
      back = 1'b0;
      reset_n = 1'b0;
      #1;
      check("async_reset_outputs", {digits, wr_en, pos, done, err}, '0);
      check("async_reset_state", W'(state), W'(1));
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   int pulses;

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 4'h1, 1'b0, 16'h0001, 4'b0001, 2'd1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 4'h1, 1'b0, 16'h0001, 4'b0000, 2'd1, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 4'h2, 1'b0, 16'h0021, 4'b0010, 2'd2, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 4'h2, 1'b0, 16'h0021, 4'b0000, 2'd2, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 4'h3, 1'b0, 16'h0321, 4'b0100, 2'd3, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 4'h3, 1'b0, 16'h0321, 4'b0000, 2'd3, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 4'h4, 1'b0, 16'h4321, 4'b1000, 2'd0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 4'h4, 1'b0, 16'h4321, 4'b0000, 2'd0, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 4'hA, 1'b0, 16'h4321, 4'b0000, 2'd0, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 4'hA, 1'b0, 16'h4321, 4'b0000, 2'd0, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 4'h7, 1'b0, 16'h4327, 4'b0001, 2'd1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 4'h7, 1'b0, 16'h4327, 4'b0000, 2'd1, 1'b0, 1'b0};

      // reset
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {digits, wr_en, pos, done, err}, '0);
      check("reset_state", W'(state), W'(1));
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();

      // entry 1-2-3-4, rejected digit, next entry starts over
      for (int i = 0; i < 13; i++) begin
         apply(tbl[i].en, tbl[i].clr, tbl[i].n, tbl[i].bk);
         check($sformatf("tbl_%0d", i), {digits, wr_en, pos, done, err},
               {tbl[i].d, tbl[i].w, tbl[i].p, tbl[i].dn, tbl[i].er});
      end

      // held button captures once
      do_reset(1'b0);
      apply(1'b0, 1'b0, 4'h0, 1'b0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         apply(1'b1, 1'b0, 4'h5, 1'b0);
         if (wr_en != '0) pulses++;
      end
      check("hold_pulses", W'(pulses), W'(1));
      check("hold_digit0", W'(digits[3:0]), W'(5));
      check("hold_pos", W'(pos), W'(1));
      apply(1'b0, 1'b0, 4'h0, 1'b0);

      // clear mid-entry with button held
      apply(1'b1, 1'b0, 4'h6, 1'b0);
      apply(1'b1, 1'b0, 4'h6, 1'b0);
      check("pre_clear_pos", W'(pos), W'(2));
      apply(1'b1, 1'b1, 4'h6, 1'b0);
      check("clear_digits", W'(digits), W'(0));
      check("clear_pos", W'(pos), W'(0));
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b0, 4'h8, 1'b0);
         check("clear_held_no_wr", W'(wr_en), W'(0));
      end
      apply(1'b0, 1'b0, 4'h8, 1'b0);
      apply(1'b1, 1'b0, 4'h8, 1'b0);
      check("after_clear_capture", W'(digits), W'(16'h0008));

`ifdef DIGIT_BACK_EN
      // backspace from a completed entry
      do_reset(1'b0);
      apply(1'b0, 1'b0, 4'h0, 1'b0);
      press(4'h1);
      press(4'h2);
      press(4'h3);
      press(4'h4);
      apply(1'b0, 1'b0, 4'h0, 1'b1);
      check("back_done", {digits, wr_en, pos, done, err}, W'({16'h0321, 4'b1000, 2'd3, 1'b0, 1'b0}));
      apply(1'b0, 1'b0, 4'h0, 1'b0);
      apply(1'b1, 1'b0, 4'h9, 1'b0);
      check("back_refill", {digits, wr_en, pos, done, err}, W'({16'h9321, 4'b1000, 2'd0, 1'b1, 1'b0}));
      apply(1'b0, 1'b0, 4'h0, 1'b0);
`endif

      // async reset at pos=3 with button held through release
      do_reset(1'b0);
      apply(1'b0, 1'b0, 4'h0, 1'b0);
      press(4'h1);
      press(4'h2);
      press(4'h3);
      check("pre_reset_pos", W'(pos), W'(3));
      do_reset(1'b1);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b0, 4'h2, 1'b0);
         check("reset_held_no_wr", W'(wr_en), W'(0));
      end
      apply(1'b0, 1'b0, 4'h2, 1'b0);
      apply(1'b1, 1'b0, 4'h2, 1'b0);
      check("after_reset_capture", {digits, wr_en, pos}, W'({16'h0002, 4'b0001, 2'd1}));

      // random
      for (int i = 0; i < 800; i++) begin
         logic en_n;
         en_n = ($urandom_range(0, 3) == 0) ? ~enable : enable;
         apply(en_n, ($urandom_range(0, 40) == 0), DW'($urandom_range(0, 15)),
               ($urandom_range(0, 2) == 0));
         if ((wr_en & (wr_en - 1'b1)) != '0 || (err && wr_en != '0)) begin
            vectors++;
            miscompares++;
            $display("FAIL strobe_exclusive: wr_en %b err %b", wr_en, err);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
